period_meter: RTL and testbench

- Measures the period and high time of a slow, asynchronous square wave in units of the system clock `clk`.
- Typical input: the output of a ripple clock divider.
- Used by the team to confirm divide ratios on silicon and in simulation. It is the receiving side for a divided clock: it decodes a waveform back into a cycle count.
- Single-shot measurement on request, with a registered result and a one-cycle `done` pulse.

---
 rtl/period_meter.sv | 167 ++++++++++++++++
 tb/tb_period_meter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter: single-shot measurement of the period and high time of a slow,
// asynchronous square wave, counted in clk cycles.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst        synchronous active-high reset
//   sig_in     asynchronous waveform to be measured
//   start      request one measurement (sampled only in IDLE)
//   busy       measurement in progress (ARM or MEASURE)
//   done       one-cycle pulse, result valid
//   period     measured period in clk cycles
//   high_time  clk cycles sig_in was high within the period
//   ovf        measurement timed out or saturated (valid with done)
//
// Optional build macro PERIOD_METER_AVG4_EN: measure four consecutive periods
// and report their truncated averages.
module period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CNT_W-1:0] MAX = '1;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s_sync, s_prev, rise;
  logic [CNT_W-1:0]       cnt, hcnt, cnt_p1;

  // Input synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      s_prev <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig_in};
      s_prev <= s_sync;
    end
  end

  assign s_sync = sync[SYNC_STAGES-1];
  assign rise   = s_sync & ~s_prev;

  // cnt+1 saturates so a rise landing exactly on cnt==MAX still reports all ones.
  assign cnt_p1 = (cnt == MAX) ? MAX : cnt + 1'b1;

`ifdef PERIOD_METER_AVG4_EN
  logic [CNT_W+1:0] sum, hsum, psum, hsum_n;
  logic [1:0]       nper;

  // Running totals including the period that ends on this rise.
  assign psum   = sum + {2'b00, cnt_p1};
  assign hsum_n = hsum + {2'b00, hcnt};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      period    <= '0;
      high_time <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      hcnt      <= '0;
`ifdef PERIOD_METER_AVG4_EN
      sum       <= '0;
      hsum      <= '0;
      nper      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
            cnt   <= '0;
            hcnt  <= '0;
`ifdef PERIOD_METER_AVG4_EN
            sum   <= '0;
            hsum  <= '0;
            nper  <= '0;
`endif
          end
        end

        ARM: begin
          if (rise) begin
            // s_sync is high on the rise cycle, so it already counts as high.
            state <= MEASURE;
            cnt   <= '0;
            hcnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (cnt == MAX) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            ovf       <= 1'b1;
            period    <= MAX;
            high_time <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        MEASURE: begin
          if (rise) begin
`ifdef PERIOD_METER_AVG4_EN
            if (nper == 2'd3) begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              ovf       <= 1'b0;
              period    <= CNT_W'(psum >> 2);
              high_time <= CNT_W'(hsum_n >> 2);
            end else begin
              sum  <= psum;
              hsum <= hsum_n;
              nper <= nper + 1'b1;
              cnt  <= '0;
              hcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end
`else
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            ovf       <= 1'b0;
            period    <= cnt_p1;
            high_time <= hcnt;
`endif
          end else if (cnt == MAX) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            ovf       <= 1'b1;
            period    <= MAX;
`ifdef PERIOD_METER_AVG4_EN
            high_time <= CNT_W'(hsum >> 2);
`else
            high_time <= hcnt;
`endif
          end else begin
            cnt <= cnt + 1'b1;
            if (s_sync && hcnt != MAX) hcnt <= hcnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed stimulus for period_meter with a scoreboard.
// Expected results are queued as stimulus is issued; a monitor pops and
// compares on every done pulse.
module tb_period_meter;
  localparam int CNT_W = 8;
  localparam int SS    = 2;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             ovf;
  } exp_t;

  logic             clk, rst, sig_in, start;
  logic             busy, done, ovf;
  logic [CNT_W-1:0] period, high_time;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
    .busy(busy), .done(done), .period(period), .high_time(high_time), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int p, input int h, input int o);
    exp_t e;
    e.period    = CNT_W'(p);
    e.high_time = CNT_W'(h);
    e.ovf       = o[0];
    sb.push_back(e);
  endtask

  // Drives reps periods of hi cycles high then lo cycles low; call at posedge+1.
  task automatic run_wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      sig_in = 1'b1;
      repeat (hi) @(posedge clk);
      #1;
      sig_in = 1'b0;
      repeat (lo) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns the number of edges until done is seen, or -1 after bound edges.
  task automatic wait_done(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_drain(input string name, input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk(name, sb.size(), 0);
  endtask

  // Monitor: every done pops one expectation; done must never last two cycles.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_done) chk("done_width", int'(done), 0);
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("period",    int'(period),    int'(e.period));
            chk("high_time", int'(high_time), int'(e.high_time));
            chk("ovf",       int'(ovf),       int'(e.ovf));
            chk("busy_at_done", int'(busy), 0);
          end
        end
      end
      prev_done = done;
    end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_high", int'(high_time), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    idle_cycles(4);

    // Basic clk/16 waveform, 50% duty.
    push(16, 8, 0);
    pulse_start();
    fork
      run_wave(8, 8, 8);
`ifdef PERIOD_METER_AVG4_EN
      begin wait_done(5*16+SS+3, n); chk("basic_done_seen", int'(n > 0), 1); end
`else
      begin wait_done(2*16+SS+3, n); chk("basic_done_seen", int'(n > 0), 1); end
`endif
    join
    chk("basic_busy_after", int'(busy), 0);
    wait_drain("basic_drain", 20);

    // Odd duty: 2 high, 3 low.
    idle_cycles(4);
    push(5, 2, 0);
    pulse_start();
    run_wave(2, 3, 8);
    wait_drain("odd_drain", 20);

    // start pulsed during MEASURE must be ignored.
    idle_cycles(4);
    push(10, 5, 0);
    pulse_start();
    fork
      run_wave(5, 5, 12);
      begin idle_cycles(8); chk("busy_in_measure", int'(busy), 1); pulse_start(); end
    join
    wait_drain("ignore_start_drain", 20);

    // start held across done: next measurement begins the cycle after done.
    idle_cycles(4);
    push(8, 4, 0);
    push(8, 4, 0);
    start = 1'b1;
    fork
      run_wave(4, 4, 24);
      begin
        wait_done(100, n);
        chk("held_first_done", int'(n > 0), 1);
        @(posedge clk);
        #1;
        chk("held_rearm_busy", int'(busy), 1);
        start = 1'b0;
      end
    join
    wait_drain("held_drain", 20);

    // Periods 16,16,16,20 (high 8,8,8,10) plus a terminating edge.
    idle_cycles(4);
`ifdef PERIOD_METER_AVG4_EN
    push(17, 8, 0);
`else
    push(16, 8, 0);
`endif
    pulse_start();
    run_wave(8, 8, 3);
    run_wave(10, 10, 1);
    run_wave(4, 4, 2);
    wait_drain("avg_drain", 30);

    // ARM timeout with sig_in held low.
    sig_in = 1'b0;
    idle_cycles(4);
    push(255, 0, 1);
    pulse_start();
    wait_done(300, n);
    chk("timeout_latency", n, 256);
    wait_drain("timeout_drain", 5);

    // MEASURE saturation: one rising edge then held high.
    idle_cycles(4);
`ifdef PERIOD_METER_AVG4_EN
    push(255, 0, 1);
`else
    push(255, 255, 1);
`endif
    pulse_start();
    idle_cycles(3);
    sig_in = 1'b1;
    wait_drain("sat_drain", 300);

    // Reset in the middle of MEASURE: outputs clear, no done follows.
    sig_in = 1'b0;
    idle_cycles(4);
    pulse_start();
    idle_cycles(3);
    sig_in = 1'b1;
    idle_cycles(10);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_period", int'(period), 0);
    chk("mid_rst_high", int'(high_time), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_done", int'(done), 0);
    idle_cycles(300);
    chk("post_rst_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
